// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: upstream valid/ready/data
// and downstream valid/ready/data as seen by one stage register.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 144
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // Surrounding stages: drive the upstream bundle and the downstream ready.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // The stage register itself.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Handshaked inter-stage pipeline register with an optional skid entry.
// SKID_EN=1: main + skid entries, in_ready comes from registered state only.
// SKID_EN=0: single entry, in_ready passes out_ready through combinationally.
// out_data is driven straight from the main register.
module pipe_stage_reg #(
    parameter int DATA_W   = 144,
    parameter bit SKID_EN  = 1'b1,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_stage_reg_if.slave      pipe,
    output logic [1:0]           occ
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_out_valid;
    logic              r_skid_free;
    logic [1:0]        r_occ;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_fire;

    // Ready to upstream: with a skid entry it depends only on held state, so a
    // downstream stall never reaches the upstream stage in the same cycle.
    assign w_in_ready = (SKID_EN ? r_skid_free : (~r_out_valid | pipe.out_ready)) & ~rst;
    assign w_accept   = pipe.in_valid & w_in_ready;
    assign w_fire     = r_out_valid & pipe.out_ready;

    // Entry state machine: main/skid occupancy, data movement, flush and drain.
    always_ff @(posedge clk) begin
        // NOTE: every register here is updated with <= so all of them sample
        // the pre-edge values; blocking assignments would leak new values
        // into later statements of the same edge.
        if (rst) begin
            // NOTE: data registers are reset too, so a bubble after reset
            // presents zeros downstream just like the fixed stage registers.
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_skid_free <= 1'b1;
            r_occ       <= 2'd0;
            r_main_data <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            // Kill everything held; a simultaneous accept is dropped.
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_skid_free <= 1'b1;
            r_occ       <= 2'd0;
            if (CLR_DATA) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ST_FULL;
                        r_out_valid <= 1'b1;
                        r_occ       <= 2'd1;
                        r_main_data <= pipe.in_data;
                    end
                end
                ST_FULL: begin
                    if (w_accept && w_fire) begin
                        r_main_data <= pipe.in_data;
                    end else if (w_accept && SKID_EN) begin
                        // Downstream stalled: park the new bundle behind main.
                        r_state     <= ST_SKID;
                        r_skid_free <= 1'b0;
                        r_occ       <= 2'd2;
                        r_skid_data <= pipe.in_data;
                    end else if (w_fire) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                        r_occ       <= 2'd0;
                        if (CLR_DATA) begin
                            r_main_data <= '0;
                        end
                    end
                end
                ST_SKID: begin
                    // No accept is possible here: in_ready is low.
                    if (w_fire) begin
                        r_state     <= ST_FULL;
                        r_skid_free <= 1'b1;
                        r_occ       <= 2'd1;
                        r_main_data <= r_skid_data;
                        if (CLR_DATA) begin
                            r_skid_data <= '0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_skid_free <= 1'b1;
                    r_occ       <= 2'd0;
                end
            endcase
        end
    end

    assign pipe.in_ready  = w_in_ready;
    assign pipe.out_valid = r_out_valid;
    assign pipe.out_data  = r_main_data;
    assign occ            = r_occ;

endmodule
